mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 6, number of mux channels scanned, legal range 2..8.
REQ-002 Parameter DWELL, default 1, clock cycles sel is held per channel before sampling, legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  scan request; honoured only in IDLE.
REQ-006 abort  input  1  cancels an active scan.
REQ-007 sample_in  input  1  mux output (out_mux) being scanned.
REQ-008 sel  output  3  channel select to mux; bit-typed.
REQ-009 busy  output  1  high in SCAN state.
REQ-010 data  output  NUM_CH  assembled word; bit i = sample of channel i.
REQ-011 data_valid  output  1  data holds a complete scan.
REQ-012 data_ready  input  1  consumer accepts data when high with data_valid.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, DONE, encoded as one state register.
REQ-014 IDLE: sel=0, busy=0, data_valid=0; start=1 at an edge SHALL enter SCAN with channel index 0 and dwell counter 0.
REQ-015 SCAN: sel SHALL equal the current channel index; dwell counter increments each cycle.
REQ-016 When dwell counter equals DWELL-1, the edge SHALL capture sample_in into data[index], clear the dwell counter and advance index by 1.
REQ-017 Capture at index NUM_CH-1 SHALL move to DONE instead of advancing; index never exceeds NUM_CH-1 and sel never drives a value at or above NUM_CH.
REQ-018 Start-to-valid latency SHALL be exactly NUM_CH*DWELL cycles (6 cycles with defaults) after the edge that samples start.
REQ-019 DONE: data_valid=1, data stable, sel=0; transfer occurs on an edge with data_valid and data_ready both high, then state returns to IDLE.
REQ-020 data_ready low in DONE SHALL hold DONE and data indefinitely.
REQ-021 abort=1 in SCAN SHALL return to IDLE at that edge with no data_valid; abort SHALL have priority over a simultaneous capture.
REQ-022 abort in IDLE or DONE SHALL be ignored.
REQ-023 start while in SCAN or DONE SHALL be ignored, not queued.
REQ-024 data bits not yet captured in the current scan SHALL retain prior values; only data_valid qualifies data.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, index=0, dwell counter=0, sel=0, busy=0, data_valid=0, data=0, overriding start, abort and any in-progress scan or pending transfer.

Configuration
REQ-026 Macro SCAN_CONT_EN: when defined, a DONE transfer SHALL re-enter SCAN at index 0 on the same edge (continuous scanning, start needed only once); when undefined, a transfer returns to IDLE per REQ-019.
REQ-027 With SCAN_CONT_EN defined, abort in SCAN or DONE SHALL return to IDLE and stop continuous scanning.

Verification
REQ-028 Defaults, sample_in driven to bit sel of 6'b101101, start pulse, data_ready=1 -> sel steps 0..5 one per cycle, data_valid high 6 cycles after start, data=6'b101101.
REQ-029 DWELL=3, same stimulus -> each sel value held 3 cycles, data_valid after 18 cycles, data=6'b101101.
REQ-030 data_ready held low 10 cycles in DONE, second start pulse meanwhile -> data_valid and data stable, no new scan; single transfer when data_ready rises.
REQ-031 abort asserted on edge where sel=3 -> IDLE next cycle, busy=0, data_valid never asserted.
REQ-032 rst asserted with sel=4 mid-scan -> all outputs 0 next cycle; a following start gives a full correct scan.
REQ-033 SCAN_CONT_EN defined, data_ready=1 -> back-to-back scans, data_valid pulses every 7 cycles (6 SCAN + 1 DONE), sel restarts at 0 each time.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scans an external NUM_CH:1 mux one channel at a time and assembles the samples into one word.
// Define SCAN_CONT_EN to restart the scan automatically after every accepted word.
module mux_scan_ctrl #(
  parameter int NUM_CH = 6,
  parameter int DWELL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_in,
  output bit   [2:0]        sel,
  output logic              busy,
  output logic [NUM_CH-1:0] data,
  output logic              data_valid,
  input  logic              data_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [2:0] LAST_CH    = 3'(NUM_CH - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] dwell_cnt;

  // sel is forced to 0 outside SCAN so the mux never sees a stale channel.
  assign sel        = (state == ST_SCAN) ? idx : 3'd0;
  assign busy       = (state == ST_SCAN);
  assign data_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      dwell_cnt <= 8'd0;
      data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SCAN;
            idx       <= 3'd0;
            dwell_cnt <= 8'd0;
          end
        end
        ST_SCAN: begin
          // abort wins over a capture landing on the same edge
          if (abort) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            dwell_cnt <= 8'd0;
          end else if (dwell_cnt == DWELL_LAST) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (idx == 3'(i)) data[i] <= sample_in;
            end
            dwell_cnt <= 8'd0;
            if (idx == LAST_CH) begin
              state <= ST_DONE;
              idx   <= 3'd0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        ST_DONE: begin
`ifdef SCAN_CONT_EN
          if (abort) begin
            state <= ST_IDLE;
          end else if (data_ready) begin
            state     <= ST_SCAN;
            idx       <= 3'd0;
            dwell_cnt <= 8'd0;
          end
`else
          if (data_ready) state <= ST_IDLE;
`endif
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= 3'd0;
          dwell_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
